ysyx_040978_mul_iter: RTL and testbench

Iterative radix-2 shift-add multiplier for the RV64M MUL/MULH/MULHSU/MULHU/MULW group, sitting in the EXU beside the iterative divider. It mirrors the divider's role and handshake: the divider reduces a product back to quotient and remainder, and this block builds the 128-bit product. It accepts one operation, iterates one bit per cycle on operand magnitudes, then applies sign correction and returns a one-cycle result pulse. Results stay stable until the next accepted operation.

---
 rtl/ysyx_040978_mul_pkg.sv | 21 ++
 rtl/ysyx_040978_mul_iter_if.sv | 26 ++
 rtl/ysyx_040978_mul_abs.sv | 12 +
 rtl/ysyx_040978_mul_iter.sv | 142 ++++++++++++++
 tb/tb_ysyx_040978_mul_iter.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/ysyx_040978_mul_pkg.sv
// Shared types and widths for the iterative RV64M multiplier.
package ysyx_040978_mul_pkg;

  localparam int XLEN  = 64;
  localparam int HALF  = XLEN / 2;
  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } mul_state_e;

  // Bit1 marks the multiplicand as signed, bit0 the multiplier.
  typedef enum logic [1:0] {
    UU = 2'b00,
    SU = 2'b10,
    SS = 2'b11
  } mul_sgn_e;

endpackage

// File: rtl/ysyx_040978_mul_iter_if.sv
// Operand/result handshake bundle between the EXU and the multiplier.
interface ysyx_040978_mul_iter_if;
  import ysyx_040978_mul_pkg::*;

  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [1:0]      mul_signed;
  logic            mul_word;
  logic [XLEN-1:0] multiplicand;
  logic [XLEN-1:0] multiplier;
  logic            out_valid;
  logic [XLEN-1:0] result_hi;
  logic [XLEN-1:0] result_lo;

  modport master (
    output flush, in_valid, mul_signed, mul_word, multiplicand, multiplier,
    input  in_ready, out_valid, result_hi, result_lo
  );

  modport slave (
    input  flush, in_valid, mul_signed, mul_word, multiplicand, multiplier,
    output in_ready, out_valid, result_hi, result_lo
  );

endinterface

// File: rtl/ysyx_040978_mul_abs.sv
// Conditional two's-complement negate, used for operand magnitudes and product sign fix.
module ysyx_040978_mul_abs #(
  parameter int W = 64
) (
  input  logic [W-1:0] din,
  input  logic         neg,
  output logic [W-1:0] dout
);

  assign dout = neg ? ((~din) + {{(W-1){1'b0}}, 1'b1}) : din;

endmodule

// File: rtl/ysyx_040978_mul_iter.sv
// Iterative radix-2 shift-add multiplier for MUL/MULH/MULHSU/MULHU/MULW.
module ysyx_040978_mul_iter
  import ysyx_040978_mul_pkg::*;
(
  input logic                  clock,
  input logic                  reset,
  ysyx_040978_mul_iter_if.slave bus
);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [2*XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0]   mplier_q, mplier_d;
  logic              neg_q, neg_d;
  logic              word_q, word_d;
  logic [XLEN-1:0]   res_hi_q, res_hi_d;
  logic [XLEN-1:0]   res_lo_q, res_lo_d;
  logic              out_valid_q, out_valid_d;
  logic              in_ready_q, in_ready_d;

  logic [XLEN-1:0]   a_ext, b_ext, a_mag, b_mag;
  logic              a_neg, b_neg;
  logic [2*XLEN-1:0] acc_sum, prod;

  // Word mode sign- or zero-extends the low half so the 64-bit negate yields the true magnitude.
  always_comb begin
    if (bus.mul_word) begin
      a_neg = bus.mul_signed[1] & bus.multiplicand[HALF-1];
      b_neg = bus.mul_signed[0] & bus.multiplier[HALF-1];
      a_ext = {{HALF{a_neg}}, bus.multiplicand[HALF-1:0]};
      b_ext = {{HALF{b_neg}}, bus.multiplier[HALF-1:0]};
    end else begin
      a_neg = bus.mul_signed[1] & bus.multiplicand[XLEN-1];
      b_neg = bus.mul_signed[0] & bus.multiplier[XLEN-1];
      a_ext = bus.multiplicand;
      b_ext = bus.multiplier;
    end
  end

  ysyx_040978_mul_abs #(.W(XLEN))   u_abs_a (.din(a_ext),   .neg(a_neg), .dout(a_mag));
  ysyx_040978_mul_abs #(.W(XLEN))   u_abs_b (.din(b_ext),   .neg(b_neg), .dout(b_mag));
  ysyx_040978_mul_abs #(.W(2*XLEN)) u_abs_p (.din(acc_sum), .neg(neg_q), .dout(prod));

  // Sum including the current step, so the final edge can load the corrected product.
  assign acc_sum = acc_q + (mplier_q[0] ? mcand_q : {(2*XLEN){1'b0}});

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    neg_d       = neg_q;
    word_d      = word_q;
    res_hi_d    = res_hi_q;
    res_lo_d    = res_lo_q;
    out_valid_d = 1'b0;
    in_ready_d  = in_ready_q;
    case (state_q)
      IDLE: begin
        in_ready_d = 1'b1;
        if (bus.in_valid && in_ready_q && !bus.flush) begin
          state_d    = BUSY;
          in_ready_d = 1'b0;
          acc_d      = '0;
          mcand_d    = {{XLEN{1'b0}}, a_mag};
          mplier_d   = b_mag;
          neg_d      = a_neg ^ b_neg;
          word_d     = bus.mul_word;
          cnt_d      = bus.mul_word ? CNT_W'(HALF - 1) : CNT_W'(XLEN - 1);
        end
      end
      BUSY: begin
        if (bus.flush) begin
          state_d    = IDLE;
          in_ready_d = 1'b1;
        end else begin
          acc_d    = acc_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_d     = DONE;
            out_valid_d = 1'b1;
            cnt_d       = '0;
            if (word_q) begin
              res_hi_d = '0;
              res_lo_d = {{HALF{prod[HALF-1]}}, prod[HALF-1:0]};
            end else begin
              res_hi_d = prod[2*XLEN-1:XLEN];
              res_lo_d = prod[XLEN-1:0];
            end
          end
        end
      end
      DONE: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
      default: begin
        state_d    = IDLE;
        in_ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
      word_q      <= 1'b0;
      res_hi_q    <= '0;
      res_lo_q    <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
      word_q      <= word_d;
      res_hi_q    <= res_hi_d;
      res_lo_q    <= res_lo_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  // A flush during the result cycle withdraws the pulse.
  assign bus.out_valid = out_valid_q & ~bus.flush;
  assign bus.result_hi = res_hi_q;
  assign bus.result_lo = res_lo_q;

endmodule

// File: tb/tb_ysyx_040978_mul_iter.sv
// Scoreboard bench for the iterative multiplier: directed operations, flush, busy input, async reset.
module tb_ysyx_040978_mul_iter;
  import ysyx_040978_mul_pkg::*;

  typedef struct packed {
    logic [63:0] hi;
    logic [63:0] lo;
  } exp_t;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  exp_t exp_q[$];

  ysyx_040978_mul_iter_if bus ();

  ysyx_040978_mul_iter dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected out_valid", 128'd1, 128'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("result", {bus.result_hi, bus.result_lo}, {e.hi, e.lo});
      end
    end
  end

  task automatic start_op(input logic [1:0] sgn, input logic word,
                          input logic [63:0] a, input logic [63:0] b);
    for (int i = 0; i < 100; i++) begin
      if (bus.in_ready) break;
      @(negedge clk);
    end
    chk("in_ready before issue", {127'd0, bus.in_ready}, 128'd1);
    bus.mul_signed   = sgn;
    bus.mul_word     = word;
    bus.multiplicand = a;
    bus.multiplier   = b;
    bus.in_valid     = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count negedges until the pulse is seen; lat is the expected count from the call.
  task automatic wait_result(input int lat);
    int k;
    k = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        k = i;
        break;
      end
    end
    chk("out_valid latency", 128'(k), 128'(lat));
    @(negedge clk);
    chk("out_valid one cycle", {127'd0, bus.out_valid}, 128'd0);
  endtask

  task automatic run_op(input logic [1:0] sgn, input logic word,
                        input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] eh, input logic [63:0] el);
    exp_q.push_back('{hi: eh, lo: el});
    start_op(sgn, word, a, b);
    wait_result(word ? 33 : 65);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    n_checks         = 0;
    n_fail           = 0;
    rst              = 1'b1;
    bus.flush        = 1'b0;
    bus.in_valid     = 1'b0;
    bus.mul_signed   = UU;
    bus.mul_word     = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    #1;
    chk("reset in_ready", {127'd0, bus.in_ready}, 128'd1);
    chk("reset out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("reset results", {bus.result_hi, bus.result_lo}, 128'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    run_op(UU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFE, 64'h0000_0000_0000_0001);
    run_op(SS, 1'b0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1);

    // Flush on the 10th iteration edge: no pulse, old results retained.
    start_op(UU, 1'b0, 64'd123, 64'd456);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("in_ready after flush", {127'd0, bus.in_ready}, 128'd1);
    chk("out_valid after flush", {127'd0, bus.out_valid}, 128'd0);
    chk("results kept after flush", {bus.result_hi, bus.result_lo},
        {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF1});
    repeat (70) @(negedge clk);

    run_op(UU, 1'b0, 64'd7, 64'd6, 64'd0, 64'd42);
    run_op(SS, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           64'h4000_0000_0000_0000, 64'd0);
    run_op(SU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001);
    run_op(SS, 1'b1, 64'h0000_0000_4000_0000, 64'd2,
           64'd0, 64'hFFFF_FFFF_8000_0000);
    run_op(SS, 1'b1, 64'hDEAD_BEEF_8000_0000, 64'd2, 64'd0, 64'd0);
    run_op(UU, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_FFFF_FFFF,
           64'd0, 64'd1);

    // in_valid pulses while BUSY must not start anything.
    exp_q.push_back('{hi: 64'd0, lo: 64'd12});
    start_op(UU, 1'b0, 64'd3, 64'd4);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.multiplicand = 64'd100;
      bus.multiplier   = 64'd100;
      bus.in_valid     = 1'b1;
      chk("in_ready low while busy", {127'd0, bus.in_ready}, 128'd0);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
    end
    wait_result(55);
    repeat (3) @(negedge clk);

    // Asynchronous reset between edges mid-BUSY.
    start_op(UU, 1'b0, 64'd9, 64'd9);
    repeat (20) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async reset in_ready", {127'd0, bus.in_ready}, 128'd1);
    chk("async reset out_valid", {127'd0, bus.out_valid}, 128'd0);
    chk("async reset results", {bus.result_hi, bus.result_lo}, 128'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    run_op(SS, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd3,
           64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFA);

    repeat (5) @(negedge clk);
    chk("scoreboard drained", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
